// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the three-port SDRAM slot arbiter.
package sdram_arb_pkg;

   localparam int NUM_PORTS  = 3;
   localparam int DEF_ADDR_W = 25;
   localparam int DEF_DATA_W = 8;

   typedef logic [1:0] port_idx_t;

   localparam port_idx_t PORT_LOAD = 2'd0;
   localparam port_idx_t PORT_CPU  = 2'd1;
   localparam port_idx_t PORT_VID  = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker between the CPU and video ports.
// The pointer advances only when one of the two ports actually wins a slot.
module sdram_arb_rr (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_slot_start,
   input  logic i_req1,
   input  logic i_req2,
   input  logic i_block,
   output logic o_grant1,
   output logic o_grant2
);

   // 0: port 1 has the turn, 1: port 2 has the turn
   logic r_ptr;

   always_comb begin
      o_grant1 = 1'b0;
      o_grant2 = 1'b0;
      if (!i_block) begin
         if (i_req1 && (!r_ptr || !i_req2)) begin
            o_grant1 = 1'b1;
         end else if (i_req2) begin
            o_grant2 = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= 1'b0;
      end else if (i_slot_start) begin
         if (o_grant1) begin
            r_ptr <= 1'b1;
         end else if (o_grant2) begin
            r_ptr <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-based arbiter sharing one SDRAM controller port among loader, CPU and video.
// Optional forced refresh slots are enabled by defining SDRAM_ARB_REFRESH_EN.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int REFRESH_SLOTS = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clkref,
   input  logic              i_p0_req,
   input  logic              i_p0_we,
   input  logic [ADDR_W-1:0] i_p0_addr,
   input  logic [DATA_W-1:0] i_p0_din,
   output logic [DATA_W-1:0] o_p0_dout,
   output logic              o_p0_ack,
   input  logic              i_p1_req,
   input  logic              i_p1_we,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_din,
   output logic [DATA_W-1:0] o_p1_dout,
   output logic              o_p1_ack,
   input  logic              i_p2_req,
   input  logic              i_p2_we,
   input  logic [ADDR_W-1:0] i_p2_addr,
   input  logic [DATA_W-1:0] i_p2_din,
   output logic [DATA_W-1:0] o_p2_dout,
   output logic              o_p2_ack,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_din,
   output logic              o_mem_oe,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_dout,
   output logic              o_dbg_state
);

   logic                 r_clkref_d;
   arb_state_t           r_state;
   port_idx_t            r_grant;
   logic [NUM_PORTS-1:0] r_ack;
   logic [DATA_W-1:0]    r_dout0;
   logic [DATA_W-1:0]    r_dout1;
   logic [DATA_W-1:0]    r_dout2;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [DATA_W-1:0]    r_mem_din;
   logic                 r_mem_oe;
   logic                 r_mem_we;

   logic                 w_slot_start;
   logic                 w_force_idle;
   logic                 w_grant1;
   logic                 w_grant2;
   logic                 w_win_valid;
   port_idx_t            w_win;
   logic                 w_win_we;
   logic [ADDR_W-1:0]    w_win_addr;
   logic [DATA_W-1:0]    w_win_din;
   logic [NUM_PORTS-1:0] w_req;
   logic [NUM_PORTS-1:0] w_acked;
   logic [NUM_PORTS-1:0] w_cand;

   assign w_slot_start = i_clkref & ~r_clkref_d;
   assign w_req        = {i_p2_req, i_p1_req, i_p0_req};

   // The port completing at this boundary may still hold req; it must not win again.
   always_comb begin
      w_acked = '0;
      if (w_slot_start && r_state == ST_BUSY) begin
         w_acked[r_grant] = 1'b1;
      end
   end

   assign w_cand = w_req & ~w_acked;

`ifdef SDRAM_ARB_REFRESH_EN
   localparam int REF_W = $clog2(REFRESH_SLOTS + 1);
   logic [REF_W-1:0] r_ref_cnt;

   assign w_force_idle = (r_ref_cnt == REF_W'(REFRESH_SLOTS));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ref_cnt <= '0;
      end else if (w_slot_start) begin
         if (w_win_valid) begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
         end else begin
            r_ref_cnt <= '0;
         end
      end
   end
`else
   // Idle slots come only from bus slack; the slot budget has no effect here.
   assign w_force_idle = 1'b0 & (REFRESH_SLOTS > 0);
`endif

   sdram_arb_rr u_rr (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_slot_start (w_slot_start),
      .i_req1       (w_cand[PORT_CPU]),
      .i_req2       (w_cand[PORT_VID]),
      .i_block      (w_cand[PORT_LOAD] | w_force_idle),
      .o_grant1     (w_grant1),
      .o_grant2     (w_grant2)
   );

   assign w_win_valid = ~w_force_idle & (w_cand[PORT_LOAD] | w_grant1 | w_grant2);

   always_comb begin
      w_win = PORT_LOAD;
      if (!w_cand[PORT_LOAD]) begin
         w_win = w_grant1 ? PORT_CPU : PORT_VID;
      end
   end

   always_comb begin
      case (w_win)
         PORT_LOAD: begin
            w_win_addr = i_p0_addr;
            w_win_din  = i_p0_din;
            w_win_we   = i_p0_we;
         end
         PORT_CPU: begin
            w_win_addr = i_p1_addr;
            w_win_din  = i_p1_din;
            w_win_we   = i_p1_we;
         end
         default: begin
            w_win_addr = i_p2_addr;
            w_win_din  = i_p2_din;
            w_win_we   = i_p2_we;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      r_clkref_d <= i_clkref;
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_grant    <= PORT_LOAD;
         r_ack      <= '0;
         r_dout0    <= '0;
         r_dout1    <= '0;
         r_dout2    <= '0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_mem_oe   <= 1'b0;
         r_mem_we   <= 1'b0;
      end else begin
         r_ack <= '0;
         if (w_slot_start) begin
            // Completion of the slot that is ending, then arbitration for the next one.
            if (r_state == ST_BUSY) begin
               r_ack <= w_acked;
               if (!r_mem_we) begin
                  case (r_grant)
                     PORT_LOAD: r_dout0 <= i_mem_dout;
                     PORT_CPU:  r_dout1 <= i_mem_dout;
                     default:   r_dout2 <= i_mem_dout;
                  endcase
               end
            end
            if (w_win_valid) begin
               r_state    <= ST_BUSY;
               r_grant    <= w_win;
               r_mem_addr <= w_win_addr;
               r_mem_din  <= w_win_din;
               r_mem_we   <= w_win_we;
               r_mem_oe   <= ~w_win_we;
            end else begin
               r_state    <= ST_IDLE;
               r_mem_addr <= '0;
               r_mem_din  <= '0;
               r_mem_we   <= 1'b0;
               r_mem_oe   <= 1'b0;
            end
         end
      end
   end

   assign o_p0_ack    = r_ack[PORT_LOAD];
   assign o_p1_ack    = r_ack[PORT_CPU];
   assign o_p2_ack    = r_ack[PORT_VID];
   assign o_p0_dout   = r_dout0;
   assign o_p1_dout   = r_dout1;
   assign o_p2_dout   = r_dout2;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_din   = r_mem_din;
   assign o_mem_oe    = r_mem_oe;
   assign o_mem_we    = r_mem_we;
   assign o_dbg_state = r_state;

endmodule
